// File: rtl/spi_ram_pkg.sv
// Shared opcodes, SPI FSM state type and requester indices for the SPI/local RAM arbiter.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_RDWAIT = 2'd2
  } spi_state_e;

  localparam logic REQ_SPI = 1'b0;
  localparam logic REQ_LOC = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with one-hot grant; a tie goes to the requester
// that was not granted most recently.
module rr_arbiter2
  import spi_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Index of the requester that wins the next tie.
  logic r_prio;

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_prio == REQ_LOC) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= REQ_SPI;
    end else if (|i_req) begin
      r_prio <= o_gnt[REQ_SPI] ? REQ_LOC : REQ_SPI;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI command words into RAM accesses and shares the single RAM port
// with a local requester through a round-robin arbiter.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] i_spi_rx_data,
  input  logic                  i_spi_rx_valid,
  output logic [DATA_WIDTH-1:0] o_spi_tx_data,
  output logic                  o_spi_tx_valid,
  output logic                  o_spi_ovf,
  input  logic                  i_loc_req,
  input  logic                  i_loc_we,
  input  logic [ADDR_WIDTH-1:0] i_loc_addr,
  input  logic [DATA_WIDTH-1:0] i_loc_wdata,
  output logic                  o_loc_gnt,
  output logic                  o_loc_rvalid,
  output logic [DATA_WIDTH-1:0] o_loc_rdata,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  spi_state_e r_state, w_state_mid, w_state_d;

  logic [ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr, r_pend_addr;
  logic [DATA_WIDTH-1:0] r_pend_wdata;
  logic                  r_pend_we;

  logic [1:0]            w_op;
  logic [DATA_WIDTH-1:0] w_payload;
  logic                  w_is_access, w_capture, w_ovf;
  logic [1:0]            w_req, w_gnt;
  logic                  w_spi_gnt, w_loc_gnt;

  logic                  r_ovf;
  logic                  r_ram_en, r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic                  r_loc_rd_p1, r_loc_rvalid;
  logic                  r_spi_rd_p1, r_spi_rd_p2;
  logic                  r_tx_valid;
  logic [DATA_WIDTH-1:0] r_tx_data;

  assign w_op        = i_spi_rx_data[DATA_WIDTH+1:DATA_WIDTH];
  assign w_payload   = i_spi_rx_data[DATA_WIDTH-1:0];
  assign w_is_access = i_spi_rx_valid && (w_op == CMD_WR_DATA || w_op == CMD_RD_DATA);

  assign w_req[REQ_SPI] = (r_state == S_PEND);
  assign w_req[REQ_LOC] = i_loc_req;

  rr_arbiter2 u_rr_arbiter2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign w_spi_gnt = w_gnt[REQ_SPI];
  assign w_loc_gnt = w_gnt[REQ_LOC];

  // The FSM transition is applied first; an access command is then judged
  // against the post-transition state, so a command can follow a write grant.
  always_comb begin
    w_state_mid = r_state;
    w_state_d   = r_state;
    w_capture   = 1'b0;
    w_ovf       = 1'b0;
    unique case (r_state)
      S_PEND:   if (w_spi_gnt) w_state_mid = r_pend_we ? S_IDLE : S_RDWAIT;
      S_RDWAIT: if (r_tx_valid) w_state_mid = S_IDLE;
      default:  w_state_mid = r_state;
    endcase
    w_state_d = w_state_mid;
    if (w_is_access) begin
      if (w_state_mid == S_IDLE) begin
        w_capture = 1'b1;
        w_state_d = S_PEND;
      end else begin
        w_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ovf   <= w_ovf;
      if (i_spi_rx_valid && w_op == CMD_WR_ADDR) r_wr_addr <= w_payload;
      if (i_spi_rx_valid && w_op == CMD_RD_ADDR) r_rd_addr <= w_payload;
      if (w_capture) begin
        r_pend_we    <= (w_op == CMD_WR_DATA);
        r_pend_addr  <= (w_op == CMD_WR_DATA) ? r_wr_addr : r_rd_addr;
        r_pend_wdata <= (w_op == CMD_WR_DATA) ? w_payload : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_en <= w_spi_gnt | w_loc_gnt;
      if (w_spi_gnt) begin
        r_ram_we    <= r_pend_we;
        r_ram_addr  <= r_pend_addr;
        r_ram_wdata <= r_pend_wdata;
      end else if (w_loc_gnt) begin
        r_ram_we    <= i_loc_we;
        r_ram_addr  <= i_loc_addr;
        r_ram_wdata <= i_loc_wdata;
      end
    end
  end

  // Read tags follow the access through the RAM latency to route the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loc_rd_p1  <= 1'b0;
      r_loc_rvalid <= 1'b0;
      r_spi_rd_p1  <= 1'b0;
      r_spi_rd_p2  <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_loc_rd_p1  <= w_loc_gnt & ~i_loc_we;
      r_loc_rvalid <= r_loc_rd_p1;
      r_spi_rd_p1  <= w_spi_gnt & ~r_pend_we;
      r_spi_rd_p2  <= r_spi_rd_p1;
      r_tx_valid   <= r_spi_rd_p2;
      if (r_spi_rd_p2) r_tx_data <= i_ram_rdata;
    end
  end

  assign o_spi_tx_data  = r_tx_data;
  assign o_spi_tx_valid = r_tx_valid;
  assign o_spi_ovf      = r_ovf;
  assign o_loc_gnt      = w_loc_gnt;
  assign o_loc_rvalid   = r_loc_rvalid;
  assign o_loc_rdata    = i_ram_rdata;
  assign o_ram_en       = r_ram_en;
  assign o_ram_we       = r_ram_we;
  assign o_ram_addr     = r_ram_addr;
  assign o_ram_wdata    = r_ram_wdata;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Randomised bench for spi_ram_arbiter: a slot-scheduled reference model checked every
// cycle, plus directed sequences with hand-computed literal expectations.
module tb_spi_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       spi_ovf;
  logic       loc_req, loc_we;
  logic [7:0] loc_addr, loc_wdata;
  logic       loc_gnt, loc_rvalid;
  logic [7:0] loc_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;

  spi_ram_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_spi_rx_data  (spi_rx_data),
    .i_spi_rx_valid (spi_rx_valid),
    .o_spi_tx_data  (spi_tx_data),
    .o_spi_tx_valid (spi_tx_valid),
    .o_spi_ovf      (spi_ovf),
    .i_loc_req      (loc_req),
    .i_loc_we       (loc_we),
    .i_loc_addr     (loc_addr),
    .i_loc_wdata    (loc_wdata),
    .o_loc_gnt      (loc_gnt),
    .o_loc_rvalid   (loc_rvalid),
    .o_loc_rdata    (loc_rdata),
    .o_ram_en       (ram_en),
    .o_ram_we       (ram_we),
    .o_ram_addr     (ram_addr),
    .o_ram_wdata    (ram_wdata),
    .i_ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM; contents cleared on reset.
  logic [7:0] mem [256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      ram_rdata <= 8'h00;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events scheduled into slots indexed by cycle modulo 4.
  bit         sl_en [4], sl_we [4], sl_loc [4], sl_rv [4], sl_tx [4], sl_ovf [4];
  logic [7:0] sl_addr [4], sl_wd [4], sl_rd [4], sl_txd [4];
  logic [7:0] shadow [256];
  bit         m_pend, m_pend_we, m_rd_wait, m_prio_loc, m_loc_gnt;
  logic [7:0] m_pend_addr, m_pend_data, m_wr_addr, m_rd_addr, m_tx_data;
  int         cyc = 0;

  initial begin : model
    int ci, n1, n2;
    bit spi_r, loc_r, any, win_loc;
    logic [1:0] op;
    logic [7:0] pl, v;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_tx_valid", spi_tx_valid, 0);
        chk("rst_tx_data", spi_tx_data, 0);
        chk("rst_ovf", spi_ovf, 0);
        chk("rst_loc_gnt", loc_gnt, 0);
        chk("rst_loc_rvalid", loc_rvalid, 0);
        chk("rst_loc_rdata", loc_rdata, 0);
        m_pend = 0; m_pend_we = 0; m_rd_wait = 0; m_prio_loc = 0; m_loc_gnt = 0;
        m_pend_addr = 0; m_pend_data = 0; m_wr_addr = 0; m_rd_addr = 0; m_tx_data = 0;
        for (int i = 0; i < 4; i++) begin
          sl_en[i] = 0; sl_we[i] = 0; sl_loc[i] = 0; sl_rv[i] = 0; sl_tx[i] = 0; sl_ovf[i] = 0;
          sl_addr[i] = 0; sl_wd[i] = 0; sl_rd[i] = 0; sl_txd[i] = 0;
        end
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
      end else begin
        ci = cyc % 4; n1 = (cyc + 1) % 4; n2 = (cyc + 2) % 4;
        // Outputs due this cycle.
        chk("ram_en", ram_en, sl_en[ci]);
        if (sl_en[ci]) begin
          chk("ram_we", ram_we, sl_we[ci]);
          chk("ram_addr", ram_addr, sl_addr[ci]);
          if (sl_we[ci]) chk("ram_wdata", ram_wdata, sl_wd[ci]);
        end
        chk("loc_rvalid", loc_rvalid, sl_rv[ci]);
        if (sl_rv[ci]) chk("loc_rdata", loc_rdata, sl_rd[ci]);
        chk("tx_valid", spi_tx_valid, sl_tx[ci]);
        if (sl_tx[ci]) m_tx_data = sl_txd[ci];
        chk("tx_data", spi_tx_data, m_tx_data);
        chk("ovf", spi_ovf, sl_ovf[ci]);
        // The RAM performs this cycle's access.
        if (sl_en[ci]) begin
          if (sl_we[ci]) shadow[sl_addr[ci]] = sl_wd[ci];
          else begin
            v = shadow[sl_addr[ci]];
            if (sl_loc[ci]) begin sl_rv[n1] = 1; sl_rd[n1] = v; end
            else begin sl_tx[n2] = 1; sl_txd[n2] = v; end
          end
        end
        // Arbitration.
        spi_r   = m_pend;
        loc_r   = loc_req;
        any     = spi_r | loc_r;
        win_loc = (spi_r && loc_r) ? m_prio_loc : loc_r;
        m_loc_gnt = any && win_loc;
        chk("loc_gnt", loc_gnt, m_loc_gnt);
        if (any) begin
          m_prio_loc = !win_loc;
          sl_en[n1]  = 1;
          sl_loc[n1] = win_loc;
          sl_we[n1]  = win_loc ? loc_we : m_pend_we;
          sl_addr[n1] = win_loc ? loc_addr : m_pend_addr;
          sl_wd[n1]  = win_loc ? loc_wdata : m_pend_data;
        end
        // SPI side: the answer or grant frees the channel before new commands are judged.
        if (sl_tx[ci]) m_rd_wait = 0;
        if (any && !win_loc) begin
          m_pend = 0;
          if (!m_pend_we) m_rd_wait = 1;
        end
        if (spi_rx_valid) begin
          op = spi_rx_data[9:8];
          pl = spi_rx_data[7:0];
          if (op == 2'b00) m_wr_addr = pl;
          else if (op == 2'b10) m_rd_addr = pl;
          else if (m_pend || m_rd_wait) sl_ovf[n1] = 1;
          else begin
            m_pend      = 1;
            m_pend_we   = (op == 2'b01);
            m_pend_addr = (op == 2'b01) ? m_wr_addr : m_rd_addr;
            m_pend_data = (op == 2'b01) ? pl : 8'h00;
          end
        end
        sl_en[ci] = 0; sl_rv[ci] = 0; sl_tx[ci] = 0; sl_ovf[ci] = 0; sl_loc[ci] = 0;
      end
      cyc++;
    end
  end

  task automatic rx(input logic [9:0] w);
    spi_rx_valid = 1'b1;
    spi_rx_data  = w;
    @(negedge clk);
    spi_rx_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int txc;
    logic [1:0] op;
    logic [7:0] pl;
    rst_n = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = '0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SPI write of 0xA5 to 0x3C.
    rx(10'h03C);
    rx(10'h1A5);
    @(negedge clk); #2;
    chk("wr_ram_en", ram_en, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 8'h3C);
    chk("wr_ram_wdata", ram_wdata, 8'hA5);
    @(negedge clk); #2;
    chk("wr_single_cycle", ram_en, 0);

    // SPI read back from 0x3C.
    @(negedge clk);
    rx(10'h23C);
    rx(10'h300);
    @(negedge clk); #2;
    chk("rd_ram_en", ram_en, 1);
    chk("rd_ram_we", ram_we, 0);
    chk("rd_ram_addr", ram_addr, 8'h3C);
    @(negedge clk);
    @(negedge clk); #2;
    chk("rd_tx_valid", spi_tx_valid, 1);
    chk("rd_tx_data", spi_tx_data, 8'hA5);
    @(negedge clk); #2;
    chk("rd_tx_pulse", spi_tx_valid, 0);

    // Contention straight after reset: SPI wins first.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rx(10'h177);
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h10;
    #2;
    chk("cont_spi_first", loc_gnt, 0);
    @(negedge clk); #2;
    chk("cont_loc_next", loc_gnt, 1);
    chk("cont_spi_ram_we", ram_we, 1);
    chk("cont_spi_ram_addr", ram_addr, 8'h00);
    @(negedge clk);
    loc_req = 1'b0;
    #2;
    chk("cont_loc_ram_en", ram_en, 1);
    chk("cont_loc_ram_addr", ram_addr, 8'h10);

    // Local burst of four writes.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'(i); loc_wdata = 8'(8'h40 + i);
      #2;
      chk("burst_gnt", loc_gnt, 1);
      if (i > 0) begin
        chk("burst_ram_en", ram_en, 1);
        chk("burst_ram_addr", ram_addr, i - 1);
      end
      @(negedge clk);
    end
    loc_req = 1'b0;
    #2;
    chk("burst_last_addr", ram_addr, 3);
    @(negedge clk); #2;
    chk("burst_end", ram_en, 0);

    // Overflow: a second read while the first is in flight.
    @(negedge clk);
    rx(10'h300);
    rx(10'h300);
    #2;
    chk("ovf_pulse", spi_ovf, 1);
    @(negedge clk); #2;
    chk("ovf_single", spi_ovf, 0);
    txc = 0;
    for (int i = 0; i < 8; i++) begin
      if (spi_tx_valid) txc++;
      @(negedge clk); #2;
    end
    chk("ovf_one_tx", txc, 1);

    // Reset the cycle after a read grant.
    rx(10'h300);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #2;
    chk("rst_mid_ram_en", ram_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    txc = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (spi_tx_valid) txc++;
      @(negedge clk);
    end
    chk("rst_mid_no_tx", txc, 0);
    rx(10'h300);
    @(negedge clk); #2;
    chk("rst_mid_idle_again", ram_en, 1);
    repeat (4) @(negedge clk);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; spi_rx_valid = 1'b0; loc_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        if (loc_req && m_loc_gnt) loc_req = 1'b0;
        if (!loc_req && $urandom_range(0, 99) < 45) begin
          loc_req   = 1'b1;
          loc_we    = 1'($urandom_range(0, 1));
          loc_addr  = 8'($urandom_range(0, 15));
          loc_wdata = 8'($urandom);
        end
        op = 2'($urandom_range(0, 3));
        pl = op[0] ? 8'($urandom) : 8'($urandom_range(0, 15));
        spi_rx_valid = ($urandom_range(0, 99) < 35);
        spi_rx_data  = {op, pl};
        @(negedge clk);
      end
    end
    spi_rx_valid = 1'b0;
    loc_req = 1'b0;
    repeat (6) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
